// File: rtl/pong_scoreboard.sv
// Pong game scoreboard: tracks both players' scores, the post-point serve freeze
// and game-over state, and drives a 4-digit multiplexed seven-segment display.
module pong_scoreboard #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       p1_pt,
  input  logic       p2_pt,
  input  logic       seg_tick,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       serve_hold,
  output logic       game_over,
  output logic       winner,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [3:0]       WIN_S     = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [7:0]       SEG_DASH  = 8'b1011_1111;
  localparam logic [7:0]       SEG_P     = 8'b1000_1100;
  localparam logic [7:0]       SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HOLD = 2'd2, OVER = 2'd3} state_t;

  state_t           state_r, state_s;
  logic [3:0]       p1_r, p1_s, p2_r, p2_s;
  logic [3:0]       p1_inc_s, p2_inc_s;
  logic             winner_r, winner_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             serve_r, over_r;
  logic [1:0]       idx_r;
  logic [3:0]       an_r;
  logic [7:0]       seg_r;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] digit_seg(input logic [1:0] idx, input state_t st,
                                           input logic [3:0] s1, input logic [3:0] s2,
                                           input logic w);
    logic [7:0] s;
    case (st)
      PLAY, HOLD: begin
        case (idx)
          2'd3:    s = seg7(s1);
          2'd0:    s = seg7(s2);
          default: s = SEG_DASH;
        endcase
      end
      OVER: begin
        case (idx)
          2'd3:    s = SEG_P;
          2'd2:    s = seg7({3'b000, w} + 4'd1);
          default: s = SEG_BLANK;
        endcase
      end
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign p1_inc_s = p1_r + 4'd1;
  assign p2_inc_s = p2_r + 4'd1;

  // Next-state logic: en low beats clr, clr beats everything else.
  always_comb begin
    state_s  = state_r;
    p1_s     = p1_r;
    p2_s     = p2_r;
    winner_s = winner_r;
    cnt_s    = cnt_r;
    if (!en) begin
      state_s  = IDLE;
      p1_s     = 4'd0;
      p2_s     = 4'd0;
      winner_s = 1'b0;
      cnt_s    = '0;
    end else if (clr) begin
      state_s  = PLAY;
      p1_s     = 4'd0;
      p2_s     = 4'd0;
      winner_s = 1'b0;
      cnt_s    = '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s  = PLAY;
          p1_s     = 4'd0;
          p2_s     = 4'd0;
          winner_s = 1'b0;
          cnt_s    = '0;
        end
        PLAY: begin
          if (p1_pt && !p2_pt) begin
            p1_s = p1_inc_s;
            if (p1_inc_s == WIN_S) begin
              state_s  = OVER;
              winner_s = 1'b0;
            end else begin
              state_s = HOLD;
              cnt_s   = HOLD_LOAD;
            end
          end else if (p2_pt && !p1_pt) begin
            p2_s = p2_inc_s;
            if (p2_inc_s == WIN_S) begin
              state_s  = OVER;
              winner_s = 1'b1;
            end else begin
              state_s = HOLD;
              cnt_s   = HOLD_LOAD;
            end
          end else begin
            state_s = PLAY;
          end
        end
        HOLD: begin
          if (cnt_r == '0) begin
            state_s = PLAY;
          end else begin
            cnt_s = cnt_r - CNT_W'(1);
          end
        end
        OVER:    state_s = OVER;
        default: state_s = IDLE;
      endcase
    end
  end

  // Game state, scores and status flags, aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      p1_r     <= 4'd0;
      p2_r     <= 4'd0;
      winner_r <= 1'b0;
      cnt_r    <= '0;
      serve_r  <= 1'b0;
      over_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      p1_r     <= p1_s;
      p2_r     <= p2_s;
      winner_r <= winner_s;
      cnt_r    <= cnt_s;
      serve_r  <= (state_s == HOLD) || (state_s == OVER);
      over_r   <= (state_s == OVER);
    end
  end

  // Display scan: the index steps on seg_tick; an/seg follow it one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= 2'd0;
      an_r  <= 4'b1110;
      seg_r <= SEG_DASH;
    end else begin
      idx_r <= seg_tick ? idx_r + 2'd1 : idx_r;
      an_r  <= ~(4'b0001 << idx_r);
      seg_r <= digit_seg(idx_r, state_r, p1_r, p2_r, winner_r);
    end
  end

  assign p1_score   = p1_r;
  assign p2_score   = p2_r;
  assign serve_hold = serve_r;
  assign game_over  = over_r;
  assign winner     = winner_r;
  assign an         = an_r;
  assign seg        = seg_r;

endmodule

// File: tb/tb_pong_scoreboard.sv
// Testbench for pong_scoreboard: directed scenarios plus random stimulus, all
// checked every cycle against a behavioural game model.
module tb_pong_scoreboard;

  localparam int WIN  = 3;
  localparam int HOLD = 4;
  localparam int M_IDLE = 0, M_PLAY = 1, M_HOLD = 2, M_OVER = 3;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
  logic p1_pt = 1'b0, p2_pt = 1'b0, seg_tick = 1'b0;
  logic [3:0] p1_score, p2_score, an;
  logic [7:0] seg;
  logic serve_hold, game_over, winner;

  int n_checks = 0;
  int n_fail   = 0;

  pong_scoreboard #(.WIN_SCORE(WIN), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .p1_pt(p1_pt), .p2_pt(p2_pt),
    .seg_tick(seg_tick), .p1_score(p1_score), .p2_score(p2_score),
    .serve_hold(serve_hold), .game_over(game_over), .winner(winner), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the game
  int m_mode = M_IDLE, m_left = 0, m_p1 = 0, m_p2 = 0, m_win = 0, m_idx = 0;
  logic [3:0] m_an  = 4'b1110;
  logic [7:0] m_seg = 8'hBF;

  function automatic logic [7:0] enc(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] disp(input int i, input int mode, input int s1,
                                      input int s2, input int w);
    if (mode == M_IDLE) return 8'hBF;
    if (mode == M_OVER) return (i == 3) ? 8'h8C : (i == 2) ? enc(w + 1) : 8'hFF;
    return (i == 3) ? enc(s1) : (i == 0) ? enc(s2) : 8'hBF;
  endfunction

  // Reference update and full comparison once per clock.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_mode = M_IDLE; m_left = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_idx = 0;
      m_an = 4'b1110; m_seg = 8'hBF;
    end else begin
      m_an  = 4'b1111 & ~(4'(1) << m_idx);
      m_seg = disp(m_idx, m_mode, m_p1, m_p2, m_win);
      if (seg_tick) m_idx = (m_idx + 1) % 4;
      if (!en) begin
        m_mode = M_IDLE; m_p1 = 0; m_p2 = 0; m_win = 0; m_left = 0;
      end else if (clr) begin
        m_mode = M_PLAY; m_p1 = 0; m_p2 = 0; m_win = 0; m_left = 0;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_PLAY;
      end else if (m_mode == M_PLAY && (p1_pt != p2_pt)) begin
        if (p1_pt) m_p1++; else m_p2++;
        if (m_p1 == WIN || m_p2 == WIN) begin
          m_mode = M_OVER; m_win = p1_pt ? 0 : 1;
        end else begin
          m_mode = M_HOLD; m_left = HOLD;
        end
      end else if (m_mode == M_HOLD) begin
        m_left--;
        if (m_left == 0) m_mode = M_PLAY;
      end
    end
    chk("p1_score", 32'(p1_score), 32'(m_p1));
    chk("p2_score", 32'(p2_score), 32'(m_p2));
    chk("serve_hold", 32'(serve_hold), 32'(m_mode == M_HOLD || m_mode == M_OVER));
    chk("game_over", 32'(game_over), 32'(m_mode == M_OVER));
    chk("winner", 32'(winner), 32'(m_win));
    chk("an", 32'(an), 32'(m_an));
    chk("seg", 32'(seg), 32'(m_seg));
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_p1();
    p1_pt = 1'b1; cyc(1); p1_pt = 1'b0;
  endtask

  task automatic pulse_p2();
    p2_pt = 1'b1; cyc(1); p2_pt = 1'b0;
  endtask

  task automatic tick();
    seg_tick = 1'b1; cyc(1); seg_tick = 1'b0; cyc(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_cnt;
    bit found3, found2;
    logic [3:0] seq [4];
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset held with pulses applied
    en = 1'b1; p1_pt = 1'b1; p2_pt = 1'b0; seg_tick = 1'b1;
    cyc(2);
    p1_pt = 1'b0; p2_pt = 1'b1; cyc(1);
    p2_pt = 1'b0; seg_tick = 1'b0;
    chk("rst_p1", 32'(p1_score), 32'd0);
    chk("rst_p2", 32'(p2_score), 32'd0);
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_seg", 32'(seg), 32'h0BF);
    rst_n = 1'b1;
    cyc(1);

    // Single p1 point: exactly HOLD frozen cycles, p1 pulse inside hold ignored
    pulse_p1();
    chk("pt_p1", 32'(p1_score), 32'd1);
    hold_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (serve_hold) hold_cnt++;
      p1_pt = (i == 1);
      cyc(1);
    end
    p1_pt = 1'b0;
    chk("hold_len", 32'(hold_cnt), 32'(HOLD));
    chk("hold_ignore", 32'(p1_score), 32'd1);

    // Simultaneous points ignored
    p1_pt = 1'b1; p2_pt = 1'b1; cyc(1); p1_pt = 1'b0; p2_pt = 1'b0;
    chk("dual_p1", 32'(p1_score), 32'd1);
    chk("dual_p2", 32'(p2_score), 32'd0);
    chk("dual_hold", 32'(serve_hold), 32'd0);

    // P2 wins
    for (int k = 0; k < WIN; k++) begin
      pulse_p2();
      if (k < WIN - 1) cyc(HOLD + 1);
    end
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_winner", 32'(winner), 32'd1);
    found3 = 0; found2 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (an == 4'b0111) begin found3 = 1; chk("over_d3", 32'(seg), 32'h08C); end
      if (an == 4'b1011) begin found2 = 1; chk("over_d2", 32'(seg), 32'h0A4); end
    end
    chk("over_scan", 32'({found3, found2}), 32'd3);
    pulse_p1(); pulse_p2(); cyc(2);
    chk("over_frozen", 32'(p2_score), 32'(WIN));
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clr_p2", 32'(p2_score), 32'd0);
    chk("clr_over", 32'(game_over), 32'd0);

    // en dropped mid-HOLD, then scan sequence in IDLE
    pulse_p1(); cyc(1);
    en = 1'b0; cyc(1);
    chk("en_hold", 32'(serve_hold), 32'd0);
    chk("en_p1", 32'(p1_score), 32'd0);
    for (int i = 0; i < 4 && an != 4'b1110; i++) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("scan_an", 32'(an), 32'(seq[i]));
    end
    en = 1'b1;

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(49) != 0);
      clr      = ($urandom_range(59) == 0);
      p1_pt    = ($urandom_range(4) == 0);
      p2_pt    = ($urandom_range(4) == 0);
      seg_tick = ($urandom_range(2) == 0);
      rst_n    = ($urandom_range(199) != 0);
      cyc(1);
    end
    rst_n = 1'b1; en = 1'b1; clr = 1'b0; p1_pt = 1'b0; p2_pt = 1'b0; seg_tick = 1'b0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_scoreboard.md
PONG_SCOREBOARD -- requirements
Module: pong_scoreboard

Interface
REQ-001 Parameter WIN_SCORE, default 7, SHALL be the score (1..9) at which a player wins.
REQ-002 Parameter HOLD_CYCLES, default 50_000_000, SHALL be the post-point freeze length in clk cycles (>=2).
REQ-003 clk  in  1  SHALL be the single system clock; all state changes occur on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  in  1  SHALL be the game-mode enable (pong switch AND mode flag); low forces IDLE.
REQ-006 clr  in  1  SHALL be the synchronous, active-high game restart (debounced centre button).
REQ-007 p1_pt, p2_pt  in  1 each  SHALL be single-cycle point pulses from the ball stage, synchronous to clk.
REQ-008 seg_tick  in  1  SHALL be a single-cycle display-scan strobe, synchronous to clk.
REQ-009 p1_score, p2_score  out  4 each  SHALL be the current scores, binary.
REQ-010 serve_hold  out  1  SHALL be high while the ball stage must freeze and re-centre.
REQ-011 game_over  out  1  SHALL be high in state OVER; winner  out  1  SHALL be 0 for P1, 1 for P2.
REQ-012 an  out  4 and seg  out  8 SHALL be active-low anodes and segments {dp,g,f,e,d,c,b,a}.

Function
REQ-013 States SHALL be IDLE, PLAY, HOLD, OVER, held in a registered state machine.
REQ-014 IDLE SHALL zero both scores, serve_hold, game_over, winner, and hold counter; IDLE->PLAY when en=1 and clr=0.
REQ-015 en=0 in any state SHALL force IDLE on the next edge, taking priority over all other inputs.
REQ-016 clr=1 with en=1 SHALL zero scores and winner, clear the hold counter, and enter PLAY next cycle, from any state.
REQ-017 In PLAY, p1_pt alone SHALL increment p1_score by 1; p2_pt alone SHALL increment p2_score by 1.
REQ-018 p1_pt and p2_pt high in the same cycle SHALL be ignored (no score change, no state change).
REQ-019 Point pulses SHALL be ignored in IDLE, HOLD, and OVER.
REQ-020 A counted point whose new score equals WIN_SCORE SHALL enter OVER next cycle with winner set to the scorer.
REQ-021 Any other counted point SHALL enter HOLD next cycle with hold counter loaded to HOLD_CYCLES-1.
REQ-022 HOLD SHALL decrement the counter each cycle and return to PLAY on the cycle after the counter reads 0 (HOLD lasts exactly HOLD_CYCLES cycles).
REQ-023 serve_hold SHALL be registered and high exactly while in HOLD or OVER.
REQ-024 OVER SHALL persist until clr or en=0; scores SHALL remain frozen.
REQ-025 Scores SHALL never exceed WIN_SCORE; no wrap-around is permitted.
REQ-026 A 2-bit scan index SHALL advance by 1 on each seg_tick, wrapping 3->0; an SHALL drive low only the selected digit (index 0 -> an=4'b1110, 3 -> 4'b0111).
REQ-027 IDLE display: all four digits '-' (seg=8'b1011_1111).
REQ-028 PLAY/HOLD display: digit3=p1_score, digit2 and digit1='-', digit0=p2_score.
REQ-029 OVER display: digit3='P' (8'b1000_1100), digit2 = winner+1, digit1 blank (8'hFF), digit0 blank.
REQ-030 Digit encodings SHALL be standard active-low 0-9 (0=8'hC0, 1=8'hF9, 2=8'hA4, 7=8'hF8); dp always off.
REQ-031 an and seg SHALL be registered, updating one cycle after the index or displayed value changes.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, scores=0, scan index=0, hold counter=0, serve_hold=0, game_over=0, winner=0, an=4'b1110, seg=8'b1011_1111.
REQ-033 Reset release mid-HOLD or mid-OVER SHALL resume from IDLE only; no prior score survives.

Verification (HOLD_CYCLES=4, WIN_SCORE=3 in bench)
REQ-034 rst_n low, en=1, pulses applied -> scores stay 0, an=1110, seg=BF; release -> PLAY next cycle.
REQ-035 PLAY, p1_pt one cycle -> p1_score=1, serve_hold=1 for exactly 4 cycles, then PLAY; p1_pt during HOLD ignored.
REQ-036 p1_pt and p2_pt same cycle -> scores unchanged, state PLAY, serve_hold stays 0.
REQ-037 p2 scores 3 points (waiting out HOLD) -> game_over=1, winner=1, scan digit3 seg=8C, digit2 seg=A4; further pulses ignored; clr -> scores 0, PLAY.
REQ-038 en dropped mid-HOLD -> IDLE next edge, scores 0, serve_hold 0; four seg_ticks -> an sequence 1101,1011,0111,1110.
